// File: rtl/tour_cmd.sv
// Knight's-tour command sequencer: splits each solver move into a vertical and a
// horizontal robot command, and passes UART commands straight through while idle.
module tour_cmd (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic        clr_cmd_rdy_UART,
   output logic [7:0]  resp
);

   localparam logic [4:0] LAST_IDX  = 5'd23;
   localparam logic [7:0] RESP_DONE = 8'hA5;
   localparam logic [7:0] RESP_MORE = 8'h5A;

   typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

   state_t     state_q, state_d;
   logic [4:0] idx_q, idx_d;

   logic       legal, up, east;
   logic [3:0] dx_mag, dy_mag;
   logic [15:0] vert_cmd, horz_cmd;

   // One-hot move to leg direction/length; anything else degrades to zero-length legs.
   always_comb begin
      legal  = 1'b1;
      up     = 1'b0;
      east   = 1'b0;
      dx_mag = 4'd0;
      dy_mag = 4'd0;
      case (move)
         8'h01: begin east = 1'b1; up = 1'b1; dx_mag = 4'd1; dy_mag = 4'd2; end
         8'h02: begin              up = 1'b1; dx_mag = 4'd1; dy_mag = 4'd2; end
         8'h04: begin              up = 1'b1; dx_mag = 4'd2; dy_mag = 4'd1; end
         8'h08: begin                         dx_mag = 4'd2; dy_mag = 4'd1; end
         8'h10: begin                         dx_mag = 4'd1; dy_mag = 4'd2; end
         8'h20: begin east = 1'b1;            dx_mag = 4'd1; dy_mag = 4'd2; end
         8'h40: begin east = 1'b1;            dx_mag = 4'd2; dy_mag = 4'd1; end
         8'h80: begin east = 1'b1; up = 1'b1; dx_mag = 4'd2; dy_mag = 4'd1; end
         default: legal = 1'b0;
      endcase
   end

   assign vert_cmd = legal ? {4'h2, (up   ? 8'h00 : 8'h7F), dy_mag} : 16'h2000;
   assign horz_cmd = legal ? {4'h3, (east ? 8'hBF : 8'h3F), dx_mag} : 16'h3000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE:   if (start_tour)  begin state_d = VERT; idx_d = 5'd0; end
         VERT:   if (clr_cmd_rdy) state_d = WAIT_V;
         WAIT_V: if (send_resp)   state_d = HORZ;
         HORZ:   if (clr_cmd_rdy) state_d = WAIT_H;
         WAIT_H: if (send_resp) begin
            if (idx_q == LAST_IDX) state_d = IDLE;
            else begin
               state_d = VERT;
               idx_d   = idx_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd              = cmd_UART;
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_MORE;
      case (state_q)
         IDLE: begin
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_DONE;
         end
         VERT: begin
            cmd     = vert_cmd;
            cmd_rdy = 1'b1;
         end
         HORZ: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b1;
         end
         WAIT_H: if (idx_q == LAST_IDX) resp = RESP_DONE;
         default: ;
      endcase
   end

   assign mv_indx = idx_q;

endmodule
